// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo1 write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo1 write port among NREQ valid/ready requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NREQ      = 4,
    parameter int unsigned  DSIZE     = 8,
    parameter int unsigned  MAX_BURST = 4,
    localparam int unsigned IDW       = $clog2(NREQ),
    localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic [DSIZE-1:0]      wdata,
    output logic                  winc,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic [CW-1:0]         beat_cnt
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic [DSIZE-1:0] data_arr [NREQ];
    logic             gnt_valid, gnt_last, at_limit, xfer, rel;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    assign gnt_valid = req_valid[grant_id_q];
    assign gnt_last  = req_last[grant_id_q];
    assign at_limit  = (beat_cnt_q == CW'(MAX_BURST - 1));
    assign busy      = (state_q == GRANT);
    assign xfer      = busy && gnt_valid && !wfull;
    // Idle-release is suppressed under wfull so a stalled grantee keeps its slot.
    assign rel       = busy && ((xfer && (gnt_last || at_limit)) || (!gnt_valid && !wfull));

    assign winc     = xfer;
    assign wdata    = data_arr[grant_id_q];
    assign grant_id = grant_id_q;
    assign beat_cnt = beat_cnt_q;

    always_comb begin
        req_ready = '0;
        if (busy && !wfull) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
                if (rel) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDW'(next_rr(32'(grant_id_q), NREQ));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
